// File: rtl/fir_out_decimator.sv
// FIR output conditioner: warm-up discard, decimation,
// round/saturate to OUT_WIDTH, and a FWFT valid/ready FIFO.
module fir_out_decimator #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 10,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 25,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK_Filter,
  input  logic                          rst_n,
  input  logic [IN_WIDTH-1:0]           filter_in,
  input  logic                          enable,
  input  logic                          clr_flags,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          ovf_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(WARMUP + 2);
  localparam int PW = $clog2(DECIM + 1);

  localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);

  localparam logic [IN_WIDTH:0] RND =
    {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [IN_WIDTH:0] OMAX =
    {{(IN_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (WARMUP == 0) ? RUN : WARM;

  state_t               state_q, state_d;
  logic [WW-1:0]        warm_cnt_q, warm_cnt_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 sv_q, sv_d;
  logic [OUT_WIDTH-1:0] sd_q, sd_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                 keep;
  logic [IN_WIDTH:0]    sum;
  logic [IN_WIDTH:0]    r;
  logic                 r_sat;
  logic [OUT_WIDTH-1:0] scaled;
  logic                 sat_evt;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  // Warm-up / decimation sequencing, advanced only on accepted samples
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    phase_d    = phase_q;
    keep       = 1'b0;
    if (enable) begin
      unique case (state_q)
        WARM: begin
          warm_cnt_d = warm_cnt_q + WW'(1);
          if (warm_cnt_d == WARM_LAST)
            state_d = RUN;
        end
        RUN: begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PHASE_LAST) ?
                    '0 : phase_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Round-half-up and clamp; one spare bit keeps the add from wrapping
  always_comb begin
    sum     = {1'b0, filter_in} + RND;
    r       = sum >> SHIFT;
    r_sat   = (r > OMAX);
    scaled  = r_sat ? {OUT_WIDTH{1'b1}} : r[OUT_WIDTH-1:0];
    sat_evt = keep && r_sat;
    sv_d    = keep;
    sd_d    = keep ? scaled : sd_q;
  end

  // FIFO bookkeeping; a full FIFO still takes a push when it pops too
  always_comb begin
    full     = (level_q == FULL_LVL);
    empty    = (level_q == '0);
    pop      = !empty && out_ready;
    push_ok  = sv_q && (!full || pop);
    drop     = sv_q && !push_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    sat_d    = sat_evt | (sat_q & ~clr_flags);
    ovf_d    = drop | (ovf_q & ~clr_flags);
  end

  // Control, scale-stage and flag registers
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      warm_cnt_q <= '0;
      phase_q    <= '0;
      sv_q       <= 1'b0;
      sd_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      phase_q    <= phase_d;
      sv_q       <= sv_d;
      sd_q       <= sd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge CLK_Filter) begin
    if (push_ok)
      mem[wr_ptr_q] <= sd_q;
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator.
// Expected values are hand-derived from the block's behaviour.
module tb_fir_out_decimator;

  logic        CLK_Filter = 1'b0;
  logic        rst_n;
  logic [19:0] filter_in;
  logic        enable;
  logic        clr_flags;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;
  logic        sat_flag;
  logic        ovf_flag;

  int checks   = 0;
  int failures = 0;
  int acc      = 0;
  bit any_v;

  localparam logic [19:0] JUNK = 20'd700000;

  always #5 CLK_Filter = ~CLK_Filter;

  fir_out_decimator dut (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .filter_in  (filter_in),
    .enable     (enable),
    .clr_flags  (clr_flags),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit is_kept(input int n);
    return (n > 25) && (((n - 26) % 4) == 0);
  endfunction

  task automatic tick();
    bit e;
    e = enable && rst_n;
    @(posedge CLK_Filter);
    #1;
    if (e) acc++;
  endtask

  task automatic push_kept(input logic [19:0] v,
                           input logic c);
    enable = 1'b1;
    while (!is_kept(acc + 1)) begin
      filter_in = JUNK;
      tick();
    end
    filter_in = v;
    clr_flags = c;
    tick();
    clr_flags = 1'b0;
    filter_in = JUNK;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    filter_in = 20'd12345;
    clr_flags = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge CLK_Filter);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", ovf_flag, 0);

    clr_flags = 1'b0;
    enable    = 1'b0;
    rst_n     = 1'b1;
    any_v     = 1'b0;
    repeat (50) begin
      tick();
      if (out_valid !== 1'b0) any_v = 1'b1;
    end
    chk("idle_valid", any_v, 0);

    enable    = 1'b1;
    filter_in = 20'd2048;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("warm_valid", out_valid,
          (i >= 27) && ((i - 27) % 4 == 0));
      if ((i >= 27) && ((i - 27) % 4 == 0))
        chk("warm_data", out_data, 2);
    end

    push_kept(20'd1535, 1'b0);
    tick();
    chk("rnd1535_v", out_valid, 1);
    chk("rnd1535_d", out_data, 1);
    push_kept(20'd1536, 1'b0);
    tick();
    chk("rnd1536_v", out_valid, 1);
    chk("rnd1536_d", out_data, 2);
    push_kept(20'd0, 1'b0);
    tick();
    chk("rnd0_v", out_valid, 1);
    chk("rnd0_d", out_data, 0);
    chk("rnd_sat", sat_flag, 0);

    push_kept(20'd353940, 1'b0);
    chk("sat_set", sat_flag, 1);
    tick();
    chk("sat_v", out_valid, 1);
    chk("sat_d", out_data, 255);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_clr", sat_flag, 0);
    push_kept(20'd353940, 1'b1);
    chk("sat_win", sat_flag, 1);
    tick();
    chk("sat2_d", out_data, 255);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_clr2", sat_flag, 0);
    chk("ovf_idle", ovf_flag, 0);

    out_ready = 1'b0;
    for (int v = 1; v <= 9; v++)
      push_kept(20'(v * 1024), 1'b0);
    chk("bp_lvl8", fifo_level, 8);
    chk("bp_noovf", ovf_flag, 0);
    tick();
    chk("bp_lvl", fifo_level, 8);
    chk("bp_ovf", ovf_flag, 1);
    chk("bp_head", out_data, 1);
    enable    = 1'b0;
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      chk("drain_v", out_valid, 1);
      chk("drain_d", out_data, j);
      tick();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_lvl", fifo_level, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_clr", ovf_flag, 0);

    out_ready = 1'b0;
    for (int v = 10; v <= 17; v++)
      push_kept(20'(v * 1024), 1'b0);
    tick();
    chk("full_lvl", fifo_level, 8);
    push_kept(20'(18 * 1024), 1'b0);
    out_ready = 1'b1;
    tick();
    chk("pp_lvl", fifo_level, 8);
    chk("pp_ovf", ovf_flag, 0);
    chk("pp_head", out_data, 11);
    enable = 1'b0;
    for (int j = 11; j <= 18; j++) begin
      chk("pp_drain", out_data, j);
      tick();
    end
    chk("pp_empty", out_valid, 0);

    out_ready = 1'b0;
    push_kept(20'd1024, 1'b0);
    push_kept(20'd353940, 1'b0);
    push_kept(20'd3072, 1'b0);
    tick();
    chk("mr_lvl3", fifo_level, 3);
    chk("mr_sat", sat_flag, 1);
    enable = 1'b0;
    rst_n  = 1'b0;
    #2;
    chk("mr_lvl0", fifo_level, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_sat0", sat_flag, 0);
    chk("mr_data", out_data, 0);
    @(negedge CLK_Filter);
    rst_n = 1'b1;
    acc   = 0;
    @(posedge CLK_Filter);
    #1;
    enable    = 1'b1;
    filter_in = 20'd2048;
    out_ready = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      tick();
      chk("mr_warm", out_valid, i == 27);
    end
    chk("mr_data2", out_data, 2);

    for (int c = 1; c <= 40; c++) begin
      enable = c[0];
      tick();
      chk("gap_valid", out_valid,
          (c >= 6) && ((c - 6) % 8 == 0));
    end
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
